// File: rtl/mips_pkg.sv
// Shared register-file constants and the writeback entry record.
package mips_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/wb_sync_fifo.sv
// Circular writeback queue: up to two pushes (push0 older) and one pop per cycle.
// Entries are exported in age order, index 0 = head (oldest).
module wb_sync_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push0_i,
   input  logic [ADDR_W-1:0] push0_rd_i,
   input  logic [DATA_W-1:0] push0_data_i,
   input  logic              push1_i,
   input  logic [ADDR_W-1:0] push1_rd_i,
   input  logic [DATA_W-1:0] push1_data_i,
   input  logic              pop_i,
   output logic [CNT_W-1:0]  count_o,
   output logic [DEPTH-1:0]  ent_valid_o,
   output logic [ADDR_W-1:0] ent_rd_o   [DEPTH],
   output logic [DATA_W-1:0] ent_data_o [DEPTH]
);
   logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [PTR_W-1:0]  wr0;
   logic [PTR_W-1:0]  wr1;

   // Write pointer derives from head + count; power-of-two depth wraps for free.
   assign wr0 = rd_ptr_q + count_q[PTR_W-1:0];
   assign wr1 = push0_i ? wr0 + PTR_W'(1) : wr0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push0_i) begin
            rd_mem_q[wr0]   <= push0_rd_i;
            data_mem_q[wr0] <= push0_data_i;
         end
         if (push1_i) begin
            rd_mem_q[wr1]   <= push1_rd_i;
            data_mem_q[wr1] <= push1_data_i;
         end
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
         count_q  <= count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
      end
   end

   assign count_o = count_q;

   for (genvar k = 0; k < DEPTH; k++) begin : g_ent
      logic [PTR_W-1:0] idx;
      assign idx            = rd_ptr_q + PTR_W'(k);
      assign ent_valid_o[k] = CNT_W'(k) < count_q;
      assign ent_rd_o[k]    = rd_mem_q[idx];
      assign ent_data_o[k]  = data_mem_q[idx];
   end
endmodule

// File: rtl/regfile_write_buffer.sv
// Register file write buffer: accepts ALU/load writebacks, drains one per cycle
// through a registered output stage, and offers a youngest-wins bypass lookup.
module regfile_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::REG_ADDR_W,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [ADDR_W-1:0] lk_addr1,
   input  logic [ADDR_W-1:0] lk_addr2,
   output logic              lk_hit1,
   output logic              lk_hit2,
   output logic [DATA_W-1:0] lk_data1,
   output logic [DATA_W-1:0] lk_data2,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);
   localparam logic [ADDR_W-1:0] ZERO_RD = ADDR_W'(mips_pkg::REG_ZERO);

   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  free;
   logic [DEPTH-1:0]  ent_valid;
   logic [ADDR_W-1:0] ent_rd   [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic              push_mem;
   logic              push_alu;
   logic              pop;
   logic              rf_we_q;
   logic [ADDR_W-1:0] rf_waddr_q;
   logic [DATA_W-1:0] rf_wdata_q;

   // Readiness uses the pre-update count only; a same-cycle pop gives no credit.
   assign free      = CNT_W'(DEPTH) - count_q;
   assign mem_ready = free >= CNT_W'(1);
   assign alu_ready = free >= (mem_valid ? CNT_W'(2) : CNT_W'(1));

   // Writes to the zero register are acknowledged but dropped.
   assign push_mem = mem_valid && mem_ready && (mem_rd != ZERO_RD);
   assign push_alu = alu_valid && alu_ready && (alu_rd != ZERO_RD);
   assign pop      = count_q != '0;

   wb_sync_fifo #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push0_i     (push_mem),
      .push0_rd_i  (mem_rd),
      .push0_data_i(mem_data),
      .push1_i     (push_alu),
      .push1_rd_i  (alu_rd),
      .push1_data_i(alu_data),
      .pop_i       (pop),
      .count_o     (count_q),
      .ent_valid_o (ent_valid),
      .ent_rd_o    (ent_rd),
      .ent_data_o  (ent_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q <= pop;
         if (pop) begin
            rf_waddr_q <= ent_rd[0];
            rf_wdata_q <= ent_data[0];
         end
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign count    = count_q;
   assign empty    = count_q == '0;
   assign full     = count_q == CNT_W'(DEPTH);

   logic [ADDR_W-1:0] lk_addr_a [2];
   logic              lk_hit_a  [2];
   logic [DATA_W-1:0] lk_data_a [2];

   assign lk_addr_a[0] = lk_addr1;
   assign lk_addr_a[1] = lk_addr2;

   // Output stage is oldest, then queue oldest to youngest; later matches override.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         lk_hit_a[p]  = 1'b0;
         lk_data_a[p] = '0;
         if (lk_addr_a[p] != ZERO_RD) begin
            if (rf_we_q && (rf_waddr_q == lk_addr_a[p])) begin
               lk_hit_a[p]  = 1'b1;
               lk_data_a[p] = rf_wdata_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
               if (ent_valid[k] && (ent_rd[k] == lk_addr_a[p])) begin
                  lk_hit_a[p]  = 1'b1;
                  lk_data_a[p] = ent_data[k];
               end
            end
         end
      end
   end

   assign lk_hit1  = lk_hit_a[0];
   assign lk_hit2  = lk_hit_a[1];
   assign lk_data1 = lk_data_a[0];
   assign lk_data2 = lk_data_a[1];
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios then random traffic, all
// checked each cycle against a queue-based reference model.
module tb_regfile_write_buffer;
   import mips_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, mem_valid;
   logic [4:0]  alu_rd, mem_rd;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  lk_addr1, lk_addr2;
   logic        lk_hit1, lk_hit2;
   logic [31:0] lk_data1, lk_data2;
   logic [2:0]  count;
   logic        empty, full;

   always #5 clk = ~clk;

   regfile_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .alu_valid(alu_valid),
      .alu_rd   (alu_rd),
      .alu_data (alu_data),
      .alu_ready(alu_ready),
      .mem_valid(mem_valid),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .mem_ready(mem_ready),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .lk_addr1 (lk_addr1),
      .lk_addr2 (lk_addr2),
      .lk_hit1  (lk_hit1),
      .lk_hit2  (lk_hit2),
      .lk_data1 (lk_data1),
      .lk_data2 (lk_data2),
      .count    (count),
      .empty    (empty),
      .full     (full)
   );

   // Reference model: pending writes in acceptance order plus the write in flight.
   wb_entry_t pend[$];
   logic      m_out_v;
   wb_entry_t m_out;
   int        n_chk = 0;
   int        n_fail = 0;
   int        max_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (a == 5'd0) return;
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].rd == a) begin
            h = 1'b1;
            d = pend[i].data;
            return;
         end
      end
      if (m_out_v && m_out.rd == a) begin
         h = 1'b1;
         d = m_out.data;
      end
   endfunction

   task automatic set_in(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad);
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      alu_valid = av; alu_rd = ard; alu_data = ad;
   endtask

   // One clock: compare everything at the falling edge, then advance the model.
   task automatic tick();
      int        free;
      logic      e_mr, e_ar, h;
      logic [31:0] d;
      wb_entry_t e;
      @(negedge clk);
      free = DEPTH - pend.size();
      e_mr = free >= 1;
      e_ar = free >= (mem_valid ? 2 : 1);
      check("count", 32'(count), 32'(pend.size()));
      check("empty", 32'(empty), 32'(pend.size() == 0));
      check("full", 32'(full), 32'(pend.size() == DEPTH));
      check("mem_ready", 32'(mem_ready), 32'(e_mr));
      check("alu_ready", 32'(alu_ready), 32'(e_ar));
      check("rf_we", 32'(rf_we), 32'(m_out_v));
      if (m_out_v) begin
         check("rf_waddr", 32'(rf_waddr), 32'(m_out.rd));
         check("rf_wdata", rf_wdata, m_out.data);
      end
      model_lookup(lk_addr1, h, d);
      check("lk_hit1", 32'(lk_hit1), 32'(h));
      check("lk_data1", lk_data1, d);
      model_lookup(lk_addr2, h, d);
      check("lk_hit2", 32'(lk_hit2), 32'(h));
      check("lk_data2", lk_data2, d);
      if (rst) begin
         pend.delete();
         m_out_v = 1'b0;
         m_out   = '0;
      end else begin
         m_out_v = pend.size() > 0;
         if (m_out_v) m_out = pend.pop_front();
         if (mem_valid && e_mr && mem_rd != 5'd0) begin
            e.rd = mem_rd; e.data = mem_data; pend.push_back(e);
         end
         if (alu_valid && e_ar && alu_rd != 5'd0) begin
            e.rd = alu_rd; e.data = alu_data; pend.push_back(e);
         end
      end
      if (pend.size() > max_cnt) max_cnt = pend.size();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (n) tick();
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      lk_addr1 = 5'd0;
      lk_addr2 = 5'd0;
      m_out_v  = 1'b0;
      m_out    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_waddr", 32'(rf_waddr), 32'h0);
      check("reset_wdata", rf_wdata, 32'h0);

      // Single write: visible to lookup in cycles 1-2, written at cycle 2.
      lk_addr1 = 5'd3;
      set_in(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
      tick();
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("single_hit_c1", 32'(lk_hit1), 32'h1);
      tick();
      check("single_we_c2", 32'(rf_we), 32'h1);
      check("single_addr_c2", 32'(rf_waddr), 32'd3);
      check("single_data_c2", rf_wdata, 32'hDEADBEEF);
      check("single_hit_c2", 32'(lk_hit1), 32'h1);
      idle(3);

      // Dual push to the same register: the younger ALU value wins the lookup.
      lk_addr1 = 5'd5;
      set_in(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
      tick();
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("dual_lk_young", lk_data1, 32'h22);
      tick();
      check("dual_first", rf_wdata, 32'h11);
      tick();
      check("dual_second", rf_wdata, 32'h22);
      idle(3);

      // Fill: two pushes per cycle until only one slot remains.
      set_in(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
      tick();
      set_in(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
      tick();
      set_in(1'b1, 5'd6, 32'hA6, 1'b1, 5'd7, 32'hA7);
      #1;
      check("fill_count3", 32'(count), 32'd3);
      check("fill_mem_ready", 32'(mem_ready), 32'h1);
      check("fill_alu_ready", 32'(alu_ready), 32'h0);
      tick();
      idle(6);

      // Zero register write is acknowledged and discarded.
      lk_addr1 = 5'd0;
      lk_addr2 = 5'd0;
      set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
      #1;
      check("zero_alu_ready", 32'(alu_ready), 32'h1);
      tick();
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check("zero_count", 32'(count), 32'h0);
      tick();
      check("zero_no_we", 32'(rf_we), 32'h0);

      // Reset while draining discards the queue and the in-flight write.
      set_in(1'b1, 5'd8, 32'hB8, 1'b1, 5'd9, 32'hB9);
      tick();
      set_in(1'b1, 5'd10, 32'hBA, 1'b1, 5'd11, 32'hBB);
      tick();
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_count", 32'(count), 32'h0);
      check("rst_we", 32'(rf_we), 32'h0);
      idle(4);

      // Back-to-back ALU stream: never stalls, occupancy stays at one.
      max_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
         lk_addr1 = 5'(i);
         tick();
      end
      idle(3);
      check("stream_max_count", 32'(max_cnt), 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         set_in($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
         lk_addr1 = 5'($urandom_range(0, 7));
         lk_addr2 = 5'($urandom_range(0, 7));
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
